// File: rtl/bram_pkg.sv
// Shared types and sizing helpers for the simple-dual-port block RAM.
package bram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  function automatic int unsigned depth_f(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned rd_latency_f(input int unsigned out_reg);
    return 32'd1 + out_reg;
  endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Registered-read memory array with per-bit write mask; no reset, no bypass,
// so the array stays a plain SB_RAM40_4K inference target.
module bram_sdp_core
  import bram_pkg::*;
#(
  parameter int unsigned DATA_W = 32'd16,
  parameter int unsigned ADDR_W = 32'd8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] wmask_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = depth_f(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Masked write: only bits with a set mask bit are updated.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(DATA_W); b++) begin
        if (wmask_i[b]) mem_q[waddr_i][b] <= wdata_i[b];
      end
    end
  end

  // Registered read returns pre-write contents on a same-edge collision.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM wrapper: clear engine, client/clear write mux,
// write-first collision bypass, optional output register and read-valid pipeline.
module bram_sdp
  import bram_pkg::*;
#(
  parameter int unsigned DATA_W         = 32'd16,
  parameter int unsigned ADDR_W         = 32'd8,
  parameter int unsigned OUT_REG        = 32'd0,
  parameter int unsigned CLEAR_ON_RESET = 32'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int unsigned RD_LAT    = rd_latency_f(OUT_REG);
  localparam state_e      RST_STATE = (CLEAR_ON_RESET != 32'd0) ? CLEAR : IDLE;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d, ptr_inc_s;
  logic              clr_s, wr_acc_s, rd_acc_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s, mem_wmask_s, core_rdata_s, rd_word_s;
  logic              coll_q;
  logic [DATA_W-1:0] byp_data_q, byp_mask_q, d1_q;
  logic [RD_LAT:0]   vld_q;

  assign clr_s     = (state_q == CLEAR);
  assign busy      = clr_s;
  assign wr_acc_s  = wr_en & ~clr_s;
  assign rd_acc_s  = rd_en & ~clr_s;
  assign ptr_inc_s = ptr_q + {{ADDR_W{1'b0}}, 1'b1};

  // Clear FSM state and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      ptr_q   <= {(ADDR_W+1){1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: the extra pointer bit flags completion once DEPTH-1 is written.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          ptr_d   = {(ADDR_W+1){1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (ptr_inc_s[ADDR_W]) begin
          state_d = IDLE;
          ptr_d   = {(ADDR_W+1){1'b0}};
        end else begin
          ptr_d   = ptr_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = {(ADDR_W+1){1'b0}};
      end
    endcase
  end

  assign mem_we_s    = clr_s | wr_acc_s;
  assign mem_waddr_s = clr_s ? ptr_q[ADDR_W-1:0] : wr_addr;
  assign mem_wdata_s = clr_s ? {DATA_W{1'b0}} : wr_data;
  assign mem_wmask_s = clr_s ? {DATA_W{1'b1}} : wr_mask;

  bram_sdp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk_i   (clk),
    .we_i    (mem_we_s),
    .waddr_i (mem_waddr_s),
    .wdata_i (mem_wdata_s),
    .wmask_i (mem_wmask_s),
    .re_i    (rd_acc_s),
    .raddr_i (rd_addr),
    .rdata_o (core_rdata_s)
  );

  // Capture the colliding write so it can be merged over the stale array word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q     <= 1'b0;
      byp_data_q <= {DATA_W{1'b0}};
      byp_mask_q <= {DATA_W{1'b0}};
    end else begin
      coll_q     <= wr_acc_s & rd_acc_s & (wr_addr == rd_addr);
      byp_data_q <= wr_data & wr_mask;
      byp_mask_q <= wr_mask;
    end
  end

  assign rd_word_s = coll_q ? ((core_rdata_s & ~byp_mask_q) | byp_data_q) : core_rdata_s;

  // Valid shift register and first output data stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= {(RD_LAT+1){1'b0}};
      d1_q  <= {DATA_W{1'b0}};
    end else begin
      vld_q <= {vld_q[RD_LAT-1:0], rd_acc_s};
      if (vld_q[0]) d1_q <= rd_word_s;
    end
  end

  assign rd_valid = vld_q[RD_LAT];

  if (OUT_REG != 32'd0) begin : g_out_reg
    logic [DATA_W-1:0] d2_q;

    // Optional extra output stage for timing.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d2_q <= {DATA_W{1'b0}};
      end else begin
        if (vld_q[1]) d2_q <= d1_q;
      end
    end

    assign rd_data = d2_q;
  end else begin : g_no_out_reg
    assign rd_data = d1_q;
  end

endmodule

// File: tb/tb_bram_sdp.sv
// Directed bench: DUT a uses defaults, DUT b uses OUT_REG=1 and CLEAR_ON_RESET=0.
module tb_bram_sdp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_clear, a_wr_en, a_rd_en, a_rd_valid, a_busy;
  logic [7:0]  a_wr_addr, a_rd_addr;
  logic [15:0] a_wr_data, a_wr_mask, a_rd_data;
  logic        b_rst_n, b_clear, b_wr_en, b_rd_en, b_rd_valid, b_busy;
  logic [7:0]  b_wr_addr, b_rd_addr;
  logic [15:0] b_wr_data, b_wr_mask, b_rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  bram_sdp u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .clear(a_clear), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_mask(a_wr_mask), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy)
  );

  bram_sdp #(.OUT_REG(32'd1), .CLEAR_ON_RESET(32'd0)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .clear(b_clear), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_mask(b_wr_mask), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input bit clr, input bit wr, input logic [7:0] wa,
                       input logic [15:0] wd, input logic [15:0] wm, input bit rd,
                       input logic [7:0] ra);
    if (!sel) begin
      a_clear = clr; a_wr_en = wr; a_wr_addr = wa; a_wr_data = wd; a_wr_mask = wm;
      a_rd_en = rd; a_rd_addr = ra;
    end else begin
      b_clear = clr; b_wr_en = wr; b_wr_addr = wa; b_wr_data = wd; b_wr_mask = wm;
      b_rd_en = rd; b_rd_addr = ra;
    end
  endtask

  task automatic idle(input bit sel);
    drive(sel, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 8'h00);
  endtask

  function automatic logic obs_valid(input bit sel);
    return sel ? b_rd_valid : a_rd_valid;
  endfunction

  function automatic logic [15:0] obs_data(input bit sel);
    return sel ? b_rd_data : a_rd_data;
  endfunction

  function automatic logic obs_busy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  // One request edge; if a read was issued, report data and edges until rd_valid.
  task automatic access(input bit sel, input bit wr, input logic [7:0] wa, input logic [15:0] wd,
                        input logic [15:0] wm, input bit rd, input logic [7:0] ra,
                        output logic [15:0] data, output int lat);
    drive(sel, 1'b0, wr, wa, wd, wm, rd, ra);
    tick();
    idle(sel);
    lat  = 99;
    data = 16'h0000;
    if (rd) begin
      for (int k = 1; k <= 6 && lat == 99; k++) begin
        tick();
        if (obs_valid(sel)) begin
          lat  = k;
          data = obs_data(sel);
        end
      end
    end
  endtask

  task automatic busy_len(input bit sel, output int n);
    n = 0;
    while (obs_busy(sel) && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    idle(1'b0); idle(1'b1);
    repeat (3) tick();
    n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_a: got %b want 1", a_busy); end
    n_tests++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid_a: got %b want 0", a_rd_valid); end
    n_tests++; if (a_rd_data !== 16'h0000) begin n_fail++; $display("FAIL rst_data_a: got %h want 0000", a_rd_data); end
    n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_b: got %b want 0", b_busy); end
    n_tests++; if (b_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid_b: got %b want 0", b_rd_valid); end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    busy_len(1'b0, n);
    n_tests++; if (n !== 256) begin n_fail++; $display("FAIL init_clear_len: got %0d want 256", n); end
  endtask

  task automatic test_clear_reads();
    logic [7:0]  addrs [3];
    logic [15:0] d;
    int          l;
    addrs = '{8'h00, 8'h7F, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, addrs[i], d, l);
      n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL cleared_data[%h]: got %h want 0000", addrs[i], d); end
      n_tests++; if (l !== 1) begin n_fail++; $display("FAIL cleared_lat[%h]: got %0d want 1", addrs[i], l); end
    end
  endtask

  task automatic test_write_read(input bit sel);
    logic [15:0] d;
    int          l;
    access(sel, 1'b1, 8'h05, 16'h1234, 16'hFFFF, 1'b0, 8'h00, d, l);
    access(sel, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 8'h05, d, l);
    n_tests++; if (d !== 16'h1234) begin n_fail++; $display("FAIL wr_rd_data[%0d]: got %h want 1234", sel, d); end
    n_tests++; if (l !== 1 + int'(sel)) begin n_fail++; $display("FAIL wr_rd_lat[%0d]: got %0d want %0d", sel, l, 1 + int'(sel)); end
  endtask

  task automatic test_collision(input bit sel);
    logic [15:0] d;
    int          l;
    access(sel, 1'b1, 8'h10, 16'hFFFF, 16'hFFFF, 1'b0, 8'h00, d, l);
    access(sel, 1'b1, 8'h10, 16'h00F0, 16'h0FF0, 1'b1, 8'h10, d, l);
    n_tests++; if (d !== 16'hF0FF) begin n_fail++; $display("FAIL coll_data[%0d]: got %h want f0ff", sel, d); end
    n_tests++; if (l !== 1 + int'(sel)) begin n_fail++; $display("FAIL coll_lat[%0d]: got %0d want %0d", sel, l, 1 + int'(sel)); end
    access(sel, 1'b1, 8'h20, 16'hABCD, 16'hFFFF, 1'b1, 8'h10, d, l);
    n_tests++; if (d !== 16'hF0FF) begin n_fail++; $display("FAIL coll_later[%0d]: got %h want f0ff", sel, d); end
    access(sel, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 8'h20, d, l);
    n_tests++; if (d !== 16'hABCD) begin n_fail++; $display("FAIL indep_write[%0d]: got %h want abcd", sel, d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    int          l;
    for (int i = 0; i < 8; i++) access(1'b0, 1'b1, 8'(i), 16'(i), 16'hFFFF, 1'b0, 8'h00, d, l);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 8'(i));
      tick();
      if (i == 0) begin
        n_tests++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_first: valid %b want 0", a_rd_valid); end
      end else begin
        n_tests++;
        if ({a_rd_valid, a_rd_data} !== {1'b1, 16'(i - 1)}) begin
          n_fail++; $display("FAIL b2b[%0d]: valid %b data %h want 1 %h", i - 1, a_rd_valid, a_rd_data, 16'(i - 1));
        end
      end
    end
    idle(1'b0);
    tick();
    n_tests++; if ({a_rd_valid, a_rd_data} !== {1'b1, 16'h0007}) begin n_fail++; $display("FAIL b2b[7]: valid %b data %h want 1 0007", a_rd_valid, a_rd_data); end
    tick();
    n_tests++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: valid %b want 0", a_rd_valid); end
  endtask

  task automatic test_clear_collide();
    logic [15:0] d;
    int          l, n;
    access(1'b0, 1'b1, 8'h05, 16'h1234, 16'hFFFF, 1'b0, 8'h00, d, l);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 8'h05);
    tick();
    idle(1'b0);
    n_tests++; if ({a_busy, a_rd_valid} !== 2'b10) begin n_fail++; $display("FAIL clr_start: busy/valid %b want 10", {a_busy, a_rd_valid}); end
    tick();
    n_tests++; if ({a_rd_valid, a_rd_data} !== {1'b1, 16'h1234}) begin n_fail++; $display("FAIL clr_inflight: valid %b data %h want 1 1234", a_rd_valid, a_rd_data); end
    repeat (10) tick();
    drive(1'b0, 1'b0, 1'b1, 8'h06, 16'hBEEF, 16'hFFFF, 1'b1, 8'h05);
    tick();
    idle(1'b0);
    tick();
    n_tests++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL busy_read_drop: valid %b want 0", a_rd_valid); end
    busy_len(1'b0, n);
    n_tests++; if (n !== 243) begin n_fail++; $display("FAIL clr_remaining: got %0d want 243", n); end
    access(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 8'h05, d, l);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL clr_addr5: got %h want 0000", d); end
    access(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 8'h06, d, l);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL busy_write_drop: got %h want 0000", d); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    int          l, n, pulses;
    access(1'b0, 1'b1, 8'h07, 16'h7777, 16'hFFFF, 1'b0, 8'h00, d, l);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 8'h07);
    tick();
    a_rst_n = 1'b0;
    idle(1'b0);
    pulses = 0;
    repeat (3) begin tick(); if (a_rd_valid) pulses++; end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_kill_read: pulses %0d want 0", pulses); end
    a_rst_n = 1'b1;
    busy_len(1'b0, n);
    n_tests++; if (n !== 256) begin n_fail++; $display("FAIL rst_clear_len1: got %0d want 256", n); end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 8'h00);
    tick();
    idle(1'b0);
    repeat (100) tick();
    a_rst_n = 1'b0;
    tick();
    n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 1", a_busy); end
    a_rst_n = 1'b1;
    busy_len(1'b0, n);
    n_tests++; if (n !== 256) begin n_fail++; $display("FAIL rst_clear_len2: got %0d want 256", n); end
  endtask

  task automatic test_retain();
    logic [15:0] d;
    int          l, pulses;
    access(1'b1, 1'b1, 8'h33, 16'h5A5A, 16'hFFFF, 1'b0, 8'h00, d, l);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 8'h33);
    tick();
    b_rst_n = 1'b0;
    idle(1'b1);
    #1;
    n_tests++; if ({b_rd_valid, b_rd_data} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL retain_rst_out: valid %b data %h want 0 0000", b_rd_valid, b_rd_data); end
    pulses = 0;
    repeat (3) begin tick(); if (b_rd_valid) pulses++; end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL retain_kill_read: pulses %0d want 0", pulses); end
    b_rst_n = 1'b1;
    tick();
    n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL retain_busy: got %b want 0", b_busy); end
    access(1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 8'h33, d, l);
    n_tests++; if (d !== 16'h5A5A) begin n_fail++; $display("FAIL retain_data: got %h want 5a5a", d); end
    n_tests++; if (l !== 2) begin n_fail++; $display("FAIL retain_lat: got %0d want 2", l); end
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_write_read(1'b0);
    test_write_read(1'b1);
    test_collision(1'b0);
    test_collision(1'b1);
    test_back_to_back();
    test_clear_collide();
    test_reset_mid();
    test_retain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
